// File: rtl/vproc_dispatcher.sv
// rtl/vproc_dispatcher.sv - in-order single-issue vector dispatcher with register scoreboard
module vproc_dispatcher #(
    parameter int ID_W     = 3,
    parameter int UNIT_CNT = 5
) (
    input  logic                clk_i,
    input  logic                sync_rst_i,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  logic [ID_W-1:0]     instr_id_i,
    input  logic [2:0]          instr_unit_i,
    input  logic [1:0]          instr_emul_i,
    input  logic                instr_rs1_vreg_i,
    input  logic [4:0]          instr_rs1_addr_i,
    input  logic                instr_rs2_vreg_i,
    input  logic [4:0]          instr_rs2_addr_i,
    input  logic                instr_rd_vreg_i,
    input  logic [4:0]          instr_rd_addr_i,
    output logic [UNIT_CNT-1:0] disp_valid_o,
    input  logic [UNIT_CNT-1:0] disp_ready_i,
    output logic [ID_W-1:0]     disp_id_o,
    output logic                cfg_valid_o,
    output logic                unit_err_o,
    input  logic [UNIT_CNT-1:0] unit_idle_i,
    input  logic [31:0]         pend_clear_i,
    output logic [31:0]         pend_vreg_o
);

    localparam logic [2:0] UNIT_CFG = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_WAIT,
        ST_ISSUE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ID_W-1:0]       r_id;
    logic [2:0]            r_unit;
    logic [31:0]           r_src_mask;
    logic [31:0]           r_rd_mask;
    logic [31:0]           r_pend;
    logic                  r_cfg_valid;
    logic                  r_unit_err;

    logic [UNIT_CNT-1:0]   w_unit_oh;
    logic                  w_handshake;
    logic                  w_accept;
    logic                  w_hazard;
    logic                  w_unit_real;
    logic                  w_cfg_fire;
    logic                  w_err_fire;
    logic [31:0]           w_set_mask;
    logic [31:0]           w_rs1_mask;
    logic [31:0]           w_rs2_mask;
    logic [31:0]           w_rd_mask;

    // Register group covered by an operand: aligned block of 1/2/4/8 registers.
    function automatic logic [31:0] f_group_mask(input logic vreg, input logic [4:0] addr,
                                                 input logic [1:0] emul);
        logic [31:0] grp;
        logic [4:0]  base;
        case (emul)
            2'd0:    begin grp = 32'h0000_0001; base = addr;                end
            2'd1:    begin grp = 32'h0000_0003; base = {addr[4:1], 1'b0};   end
            2'd2:    begin grp = 32'h0000_000F; base = {addr[4:2], 2'b00};  end
            default: begin grp = 32'h0000_00FF; base = {addr[4:3], 3'b000}; end
        endcase
        return vreg ? (grp << base) : 32'h0;
    endfunction

    assign w_rs1_mask = f_group_mask(instr_rs1_vreg_i, instr_rs1_addr_i, instr_emul_i);
    assign w_rs2_mask = f_group_mask(instr_rs2_vreg_i, instr_rs2_addr_i, instr_emul_i);
    assign w_rd_mask  = f_group_mask(instr_rd_vreg_i, instr_rd_addr_i, instr_emul_i);

    // One-hot select of the buffered instruction's unit (all zero for CFG and bad codes).
    always_comb begin
        w_unit_oh = '0;
        for (int i = 0; i < UNIT_CNT; i++) begin
            if (r_unit == 3'(i)) begin
                w_unit_oh[i] = 1'b1;
            end
        end
    end

    assign w_unit_real   = (r_unit < 3'(UNIT_CNT));
    assign w_handshake   = (r_state == ST_ISSUE) && (|(w_unit_oh & disp_ready_i));
    assign instr_ready_o = (r_state == ST_EMPTY) || w_handshake;
    assign w_accept      = instr_valid_i && instr_ready_o;
    assign w_hazard      = |((r_src_mask | r_rd_mask) & r_pend);
    assign w_cfg_fire    = (r_state == ST_WAIT) && (r_unit == UNIT_CFG) &&
                           (r_pend == 32'h0) && (&unit_idle_i);
    assign w_err_fire    = (r_state == ST_WAIT) && (r_unit > UNIT_CFG);
    assign w_set_mask    = w_handshake ? r_rd_mask : 32'h0;

    // Next-state logic for the single instruction buffer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (instr_valid_i) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_cfg_fire || w_err_fire) begin
                    w_state_next = ST_EMPTY;
                end else if (w_unit_real && !w_hazard) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_handshake) begin
                    w_state_next = instr_valid_i ? ST_WAIT : ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch the decoded instruction and its precomputed register-group masks on accept.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_id       <= '0;
            r_unit     <= 3'd0;
            r_src_mask <= 32'h0;
            r_rd_mask  <= 32'h0;
        end else if (w_accept) begin
            r_id       <= instr_id_i;
            r_unit     <= instr_unit_i;
            r_src_mask <= w_rs1_mask | w_rs2_mask;
            r_rd_mask  <= w_rd_mask;
        end
    end

    // Pending-write scoreboard: a set on the dispatch handshake overrides a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_pend <= 32'h0;
        end else begin
            r_pend <= (r_pend & ~pend_clear_i) | w_set_mask;
        end
    end

    // One-cycle retire pulses for CFG and dropped bad-unit instructions.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_cfg_valid <= 1'b0;
            r_unit_err  <= 1'b0;
        end else begin
            r_cfg_valid <= w_cfg_fire;
            r_unit_err  <= w_err_fire;
        end
    end

    assign disp_valid_o = (r_state == ST_ISSUE) ? w_unit_oh : '0;
    assign disp_id_o    = r_id;
    assign cfg_valid_o  = r_cfg_valid;
    assign unit_err_o   = r_unit_err;
    assign pend_vreg_o  = r_pend;

endmodule

// File: tb/tb_vproc_dispatcher.sv
// tb/tb_vproc_dispatcher.sv - scoreboard bench for vproc_dispatcher
module tb_vproc_dispatcher;

    localparam int ID_W = 3;
    localparam int UC   = 5;
    localparam int K_DISP = 0;
    localparam int K_CFG  = 1;
    localparam int K_ERR  = 2;

    logic            clk = 1'b0;
    logic            sync_rst;
    logic            instr_valid;
    logic            instr_ready;
    logic [ID_W-1:0] instr_id;
    logic [2:0]      instr_unit;
    logic [1:0]      instr_emul;
    logic            rs1_vreg, rs2_vreg, rd_vreg;
    logic [4:0]      rs1_addr, rs2_addr, rd_addr;
    logic [UC-1:0]   disp_valid;
    logic [UC-1:0]   disp_ready;
    logic [ID_W-1:0] disp_id;
    logic            cfg_valid;
    logic            unit_err;
    logic [UC-1:0]   unit_idle;
    logic [31:0]     pend_clear;
    logic [31:0]     pend_vreg;

    typedef struct {
        int         kind;
        logic [4:0] oh;
        logic [2:0] id;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    vproc_dispatcher #(.ID_W(ID_W), .UNIT_CNT(UC)) dut (
        .clk_i            (clk),
        .sync_rst_i       (sync_rst),
        .instr_valid_i    (instr_valid),
        .instr_ready_o    (instr_ready),
        .instr_id_i       (instr_id),
        .instr_unit_i     (instr_unit),
        .instr_emul_i     (instr_emul),
        .instr_rs1_vreg_i (rs1_vreg),
        .instr_rs1_addr_i (rs1_addr),
        .instr_rs2_vreg_i (rs2_vreg),
        .instr_rs2_addr_i (rs2_addr),
        .instr_rd_vreg_i  (rd_vreg),
        .instr_rd_addr_i  (rd_addr),
        .disp_valid_o     (disp_valid),
        .disp_ready_i     (disp_ready),
        .disp_id_o        (disp_id),
        .cfg_valid_o      (cfg_valid),
        .unit_err_o       (unit_err),
        .unit_idle_i      (unit_idle),
        .pend_clear_i     (pend_clear),
        .pend_vreg_o      (pend_vreg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int kind, input logic [4:0] oh, input logic [2:0] id, input int c);
        exp_t e;
        e.kind = kind;
        e.oh   = oh;
        e.id   = id;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic ev(input int kind, input logic [4:0] oh, input logic [2:0] id);
        exp_t e;
        n_checks++;
        if (q.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d oh %b id %0d cycle %0d, expected none",
                     kind, oh, id, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind == kind && e.oh == oh && e.id == id && e.cyc == cyc) n_pass++;
            else $display("FAIL event: got kind %0d oh %b id %0d cycle %0d, expected kind %0d oh %b id %0d cycle %0d",
                          kind, oh, id, cyc, e.kind, e.oh, e.id, e.cyc);
        end
    endtask

    // Monitor: every output event pops the next expectation.
    always @(negedge clk) begin
        if (|(disp_valid & disp_ready)) ev(K_DISP, disp_valid, disp_id);
        if (cfg_valid) ev(K_CFG, 5'b0, 3'd0);
        if (unit_err) ev(K_ERR, 5'b0, 3'd0);
    end

    // Present one instruction; returns the cycle it was accepted. Called just after a posedge.
    task automatic issue(input logic [2:0] unit, input logic [2:0] id, input logic [1:0] emul,
                         input logic r1v, input logic [4:0] r1, input logic r2v, input logic [4:0] r2,
                         input logic rdv, input logic [4:0] rd, output int acc);
        bit done;
        done        = 1'b0;
        acc         = -1;
        instr_valid = 1'b1;
        instr_unit  = unit;
        instr_id    = id;
        instr_emul  = emul;
        rs1_vreg    = r1v;
        rs1_addr    = r1;
        rs2_vreg    = r2v;
        rs2_addr    = r2;
        rd_vreg     = rdv;
        rd_addr     = rd;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                acc  = cyc;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        instr_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL accept_timeout: got no instr_ready_o for unit %0d id %0d, expected accept", unit, id);
        end
    endtask

    task automatic pulse_clear(input logic [31:0] m);
        pend_clear = m;
        @(posedge clk);
        #1;
        pend_clear = 32'h0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int a, b, p;
        sync_rst    = 1'b1;
        instr_valid = 1'b0;
        instr_id    = '0;
        instr_unit  = 3'd0;
        instr_emul  = 2'd0;
        rs1_vreg    = 1'b0;
        rs2_vreg    = 1'b0;
        rd_vreg     = 1'b0;
        rs1_addr    = 5'd0;
        rs2_addr    = 5'd0;
        rd_addr     = 5'd0;
        disp_ready  = 5'b11111;
        unit_idle   = 5'b11111;
        pend_clear  = 32'h0;
        step(2);
        sync_rst = 1'b0;
        @(negedge clk);
        check("rst_pend", pend_vreg, 32'h0);
        check("rst_disp_valid", 32'(disp_valid), 32'h0);
        check("rst_disp_id", 32'(disp_id), 32'h0);
        check("rst_cfg", 32'(cfg_valid), 32'h0);
        check("rst_err", 32'(unit_err), 32'h0);
        check("rst_ready", 32'(instr_ready), 32'h1);
        step(1);

        // Back-to-back independent: ALU rd=v1, then MUL rs1=v2 rd=v3.
        issue(3'd1, 3'd1, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, a);
        push(K_DISP, 5'b00010, 3'd1, a + 2);
        issue(3'd2, 3'd2, 2'd0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 5'd3, b);
        check("b2b_accept_cycle", 32'(b), 32'(a + 2));
        push(K_DISP, 5'b00100, 3'd2, a + 4);
        step(2);
        check("b2b_pend", pend_vreg, 32'h0000_000A);
        pulse_clear(32'h0000_000A);
        check("b2b_pend_cleared", pend_vreg, 32'h0);

        // RAW stall: ALU rd=v4 emul1 (v4,v5), then SLD rs2=v5.
        issue(3'd1, 3'd3, 2'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, a);
        push(K_DISP, 5'b00010, 3'd3, a + 2);
        issue(3'd3, 3'd4, 2'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, b);
        step(4);
        check("raw_pend", pend_vreg, 32'h0000_0030);
        check("raw_stall_valid", 32'(disp_valid), 32'h0);
        check("raw_stall_ready", 32'(instr_ready), 32'h0);
        p = cyc;
        push(K_DISP, 5'b01000, 3'd4, p + 2);
        pulse_clear(32'h0000_0030);
        step(3);
        check("raw_pend_after", pend_vreg, 32'h0);

        // Backpressure on LSU for four cycles.
        disp_ready = 5'b11110;
        issue(3'd0, 3'd5, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, a);
        step(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(disp_valid), 32'h1);
            check("bp_id", 32'(disp_id), 32'h5);
            check("bp_ready", 32'(instr_ready), 32'h0);
            check("bp_pend", pend_vreg, 32'h0);
            step(1);
        end
        disp_ready = 5'b11111;
        push(K_DISP, 5'b00001, 3'd5, cyc);
        @(negedge clk);
        check("bp_ready_on_hs", 32'(instr_ready), 32'h1);
        step(1);
        check("bp_pend_set", pend_vreg, 32'h0000_0400);
        pulse_clear(32'h0000_0400);

        // CFG drain: waits while unit 1 is busy.
        unit_idle = 5'b11101;
        issue(3'd5, 3'd6, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, a);
        step(4);
        check("cfg_wait_pulse", 32'(cfg_valid), 32'h0);
        check("cfg_wait_ready", 32'(instr_ready), 32'h0);
        unit_idle = 5'b11111;
        push(K_CFG, 5'b0, 3'd0, cyc + 1);
        step(1);
        @(negedge clk);
        check("cfg_no_disp", 32'(disp_valid), 32'h0);
        step(1);
        check("cfg_single_pulse", 32'(cfg_valid), 32'h0);
        check("cfg_back_empty", 32'(instr_ready), 32'h1);

        // Set/clear collision on v8.
        issue(3'd1, 3'd7, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, a);
        push(K_DISP, 5'b00010, 3'd7, a + 2);
        step(1);
        pend_clear = 32'h0000_0100;
        step(1);
        pend_clear = 32'h0;
        check("collision_set_wins", pend_vreg, 32'h0000_0100);

        // Bad unit code 7.
        issue(3'd7, 3'd2, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd20, a);
        push(K_ERR, 5'b0, 3'd0, a + 2);
        step(1);
        @(negedge clk);
        check("err_back_empty", 32'(instr_ready), 32'h1);
        check("err_no_disp", 32'(disp_valid), 32'h0);
        check("err_pend_kept", pend_vreg, 32'h0000_0100);
        step(1);

        // Reset while in ISSUE.
        disp_ready = 5'b00000;
        issue(3'd1, 3'd3, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12, a);
        step(1);
        @(negedge clk);
        check("rst_issue_valid_before", 32'(disp_valid), 32'h2);
        sync_rst = 1'b1;
        step(1);
        sync_rst = 1'b0;
        @(negedge clk);
        check("rst_issue_valid", 32'(disp_valid), 32'h0);
        check("rst_issue_pend", pend_vreg, 32'h0);
        check("rst_issue_id", 32'(disp_id), 32'h0);
        disp_ready = 5'b11111;
        step(1);

        // Group masks: rd=v5 emul2 covers v4..v7; rs1=v9 emul3 covers v8..v15; rs1=v2 emul3 hits.
        issue(3'd1, 3'd1, 2'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, a);
        push(K_DISP, 5'b00010, 3'd1, a + 2);
        issue(3'd4, 3'd2, 2'd3, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, b);
        check("grp_pend_f0", pend_vreg, 32'h0000_00F0);
        push(K_DISP, 5'b10000, 3'd2, b + 2);
        step(2);
        issue(3'd4, 3'd3, 2'd3, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, a);
        step(4);
        check("grp_hazard_stall", 32'(disp_valid), 32'h0);
        push(K_DISP, 5'b10000, 3'd3, cyc + 2);
        pulse_clear(32'h0000_00F0);
        step(4);

        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drained: got %0d outstanding, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vproc_dispatcher.md
Name: vproc_dispatcher

Overview:
- In-order, single-issue dispatcher between the vector decoder and the five execution units (LSU, ALU, MUL, SLD, ELEM).
- Buffers one decoded instruction and tracks pending vector-register writes in a 32-bit scoreboard.
- Stalls on RAW/WAW hazards, then hands the instruction to its unit over a valid/ready handshake.
- UNIT_CFG instructions are never sent to a unit: they wait until the machine is drained, then emit a one-cycle pulse.

Parameters:
- ID_W, 3, width of the instruction tag carried through to the unit.
- UNIT_CNT, 5, number of real units; unit codes 0..4 = LSU, ALU, MUL, SLD, ELEM; code 5 = CFG.

Ports:
- clk_i  in  1  clock.
- sync_rst_i  in  1  reset, synchronous, active-high.
- instr_valid_i  in  1  decoded instruction valid.
- instr_ready_o  out  1  dispatcher accepts instruction.
- instr_id_i  in  ID_W  instruction tag.
- instr_unit_i  in  3  target unit code.
- instr_emul_i  in  2  register group size: 1/2/4/8 regs for 0/1/2/3.
- instr_rs1_vreg_i, instr_rs2_vreg_i  in  1 each  source is a vector register.
- instr_rs1_addr_i, instr_rs2_addr_i  in  5 each  source base register.
- instr_rd_vreg_i  in  1  destination is a vector register.
- instr_rd_addr_i  in  5  destination base register.
- disp_valid_o  out  UNIT_CNT  one-hot dispatch valid.
- disp_ready_i  in  UNIT_CNT  per-unit accept.
- disp_id_o  out  ID_W  tag of the dispatched instruction.
- cfg_valid_o  out  1  one-cycle pulse: CFG instruction retired.
- unit_err_o  out  1  one-cycle pulse: unit code 6/7 was dropped.
- unit_idle_i  in  UNIT_CNT  unit has no instruction in flight.
- pend_clear_i  in  32  per-register write-complete pulses (OR of all units).
- pend_vreg_o  out  32  current scoreboard.

Behaviour:
- Reset (sync_rst_i high at clock edge):
  - state = EMPTY; pend = 0.
  - disp_valid_o, cfg_valid_o and unit_err_o = 0; disp_id_o = 0.
  - Asserting reset mid-operation discards the buffered instruction with no dispatch.
- Group mask: size S = 1 << emul; base = addr & ~(S-1); mask = ((1<<S)-1) << base.
  - Example: addr 5, emul 2 -> bits 4..7 (0x000000F0).
  - An operand with vreg = 0 contributes mask 0.
- Ready: instr_ready_o = (state==EMPTY) | (state==ISSUE & disp_ready_i[unit]). Purely combinational from state and disp_ready_i.
- States:
  - EMPTY: on instr_valid_i, latch all fields and go to WAIT.
  - WAIT:
    - Hazard = (rs1_mask | rs2_mask | rd_mask) & pend, using the registered pend.
    - CFG: when pend == 0 and &unit_idle_i, register cfg_valid_o = 1 for one cycle and go to EMPTY.
    - Unit 0..4: when hazard == 0, go to ISSUE.
    - Unit 6/7: register unit_err_o = 1 for one cycle and go to EMPTY.
  - ISSUE:
    - disp_valid_o[unit] = 1 and disp_id_o held stable until disp_ready_i[unit].
    - On handshake: pend |= rd_mask. If instr_valid_i is also high, latch the new instruction and go to WAIT; otherwise go to EMPTY.
- Outputs are registered: disp_valid_o is driven from state and the latched unit, not from inputs.
- Minimum latency: accept at cycle N -> WAIT at N+1 -> disp_valid_o at N+2. Throughput is 1 instruction per 2 cycles.
- Scoreboard update each cycle: pend_next = (pend & ~pend_clear_i) | set_mask.
  - If a bit is set and cleared in the same cycle, the set wins.
  - A clear on an unset bit is ignored.
  - A clear takes effect for the hazard check in the following cycle.
- WAR hazards are not tracked: units fetch operands in dispatch order.
- CFG drain: CFG waits for every unit to be idle, including stores with no vreg destination.

Test Plan:
- Back-to-back independent ops: ALU rd=v1 emul0, then MUL rs1=v2 rd=v3.
  - Dispatches at cycles 2 and 4 with no stall.
  - pend_vreg_o = 0x0000000A after both.
- RAW stall: ALU rd=v4 emul1 dispatched, then SLD rs2=v5.
  - SLD stays in WAIT (pend = 0x30).
  - pend_clear_i = 0x30 pulse -> SLD disp_valid_o exactly 2 cycles after the pulse.
- Backpressure: LSU dispatch with disp_ready_i[0] low for 4 cycles.
  - disp_valid_o = 5'b00001 and disp_id_o held stable for those cycles.
  - instr_ready_o low until the ready cycle; pend is set only on the handshake cycle.
- CFG drain: CFG instruction with unit_idle_i = 5'b11101 and pend = 0.
  - No pulse while unit 1 is busy.
  - unit_idle_i = 5'b11111 -> cfg_valid_o pulses exactly once, no disp_valid_o.
- Set/clear collision: dispatch rd=v8 in the same cycle as pend_clear_i = 0x100 -> bit 8 remains set.
- Bad unit and reset:
  - Unit code 7 -> unit_err_o single pulse, no dispatch, state returns to EMPTY.
  - Reset asserted while in ISSUE -> next cycle disp_valid_o = 0, pend_vreg_o = 0.
